// File: rtl/layer_compositor.sv
// Per-pixel layer compositor: priority select, frame-shadowed mask/fade,
// 2-cycle aligned VGA outputs and a per-frame collision flag.

module layer_compositor_scale #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_ch,
    input  logic [4:0]   i_mul,
    output logic [W-1:0] o_ch
);
    logic [W+4:0] w_prod;
    logic         w_unused;

    assign w_prod   = {5'd0, i_ch} * {{W{1'b0}}, i_mul};
    // i_mul <= 16, so the top bit is always zero and the low nibble is truncated
    assign o_ch     = w_prod[W+3:4];
    assign w_unused = ^{w_prod[W+4], w_prod[3:0]};
endmodule

module layer_compositor #(
    parameter int NUM_LAYERS = 8,
    parameter int COLL_A     = 1,
    parameter int COLL_B     = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       new_frame,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic                       de_in,
    input  logic [NUM_LAYERS-1:0]      layer_pe,
    input  logic [16*NUM_LAYERS-1:0]   layer_color,
    input  logic [15:0]                bg_color,
    input  logic [NUM_LAYERS-1:0]      mask_cfg,
    input  logic [3:0]                 fade_cfg,
    output logic                       vga_hsync,
    output logic                       vga_vsync,
    output logic                       vga_de,
    output logic [15:0]                vga_rgb,
    output logic [3:0]                 hit_idx,
    output logic                       collision
);
    logic [NUM_LAYERS-1:0] r_mask_sh;
    logic [3:0]            r_fade_sh;
    logic [NUM_LAYERS-1:0] w_eff;
    logic [15:0]           w_c1;
    logic [3:0]            w_idx1;
    logic [15:0]           r_c1;
    logic [3:0]            r_idx1;
    logic [3:0]            r_fade1;
    logic                  r_hs1, r_vs1, r_de1;
    logic [4:0]            w_mul;
    logic [4:0]            w_r, w_b;
    logic [5:0]            w_g;
    logic                  w_hit_now;
    logic                  r_acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mask_sh <= '1;
            r_fade_sh <= 4'd15;
        end else if (new_frame) begin
            r_mask_sh <= mask_cfg;
            r_fade_sh <= fade_cfg;
        end
    end

    assign w_eff = layer_pe & r_mask_sh;

    // Scan from lowest priority upward so the lowest set index wins.
    always_comb begin
        w_c1   = bg_color;
        w_idx1 = 4'd15;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_eff[i]) begin
                w_c1   = layer_color[16*i +: 16];
                w_idx1 = 4'(i);
            end
        end
    end

    // Fade travels with the pixel so a pixel sees one frame's config end to end.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_c1    <= '0;
            r_idx1  <= 4'd15;
            r_fade1 <= 4'd15;
            r_hs1   <= 1'b0;
            r_vs1   <= 1'b0;
            r_de1   <= 1'b0;
        end else begin
            r_c1    <= w_c1;
            r_idx1  <= w_idx1;
            r_fade1 <= r_fade_sh;
            r_hs1   <= hsync_in;
            r_vs1   <= vsync_in;
            r_de1   <= de_in;
        end
    end

    assign w_mul = {1'b0, r_fade1} + 5'd1;

    layer_compositor_scale #(.W(5)) u_scale_r (.i_ch(r_c1[15:11]), .i_mul(w_mul), .o_ch(w_r));
    layer_compositor_scale #(.W(6)) u_scale_g (.i_ch(r_c1[10:5]),  .i_mul(w_mul), .o_ch(w_g));
    layer_compositor_scale #(.W(5)) u_scale_b (.i_ch(r_c1[4:0]),   .i_mul(w_mul), .o_ch(w_b));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vga_hsync <= 1'b0;
            vga_vsync <= 1'b0;
            vga_de    <= 1'b0;
            vga_rgb   <= '0;
            hit_idx   <= 4'd15;
        end else begin
            vga_hsync <= r_hs1;
            vga_vsync <= r_vs1;
            vga_de    <= r_de1;
            vga_rgb   <= r_de1 ? {w_r, w_g, w_b} : 16'h0000;
            hit_idx   <= r_de1 ? r_idx1 : 4'd15;
        end
    end

    // Raw pe on purpose: masked-off layers still count as colliding.
    assign w_hit_now = de_in & layer_pe[COLL_A] & layer_pe[COLL_B];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc     <= 1'b0;
            collision <= 1'b0;
        end else if (new_frame) begin
            collision <= r_acc | w_hit_now;
            r_acc     <= 1'b0;
        end else begin
            r_acc     <= r_acc | w_hit_now;
        end
    end
endmodule
